// File: rtl/avm_burst_reader_pkg.sv
// avm_burst_reader_pkg: shared types and constants for the Avalon-MM burst reader.
//   state_e    - controller states
//   WORD_BYTES - byte stride between consecutive 32-bit words
//   BE_ALL     - byteenable driven on every read
package avm_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/avm_burst_reader_fifo.sv
// avm_burst_reader_fifo: synchronous show-ahead FIFO for returned read data.
//   clk, reset_n   - clock, asynchronous active-low reset
//   push, wdata    - write side
//   pop, rdata     - read side; rdata is the head word whenever !empty
//   flush          - discard all contents (wins over push/pop)
//   count, empty, full - occupancy status
module avm_burst_reader_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/avm_burst_reader.sv
// avm_burst_reader: Avalon-MM read master that fetches word_count consecutive
// 32-bit words starting at base_addr and streams them out on Avalon-ST.
//   control : start, base_addr, word_count, abort -> busy, done, aborted
//   master  : avm_address, avm_read, avm_byteenable, avm_waitrequest,
//             avm_readdata, avm_readdatavalid
//   stream  : st_data, st_valid, st_ready
// Optional macro AVM_BURST_READER_STATS_EN adds stall_cycles / bp_cycles
// saturating counters, cleared on start.
module avm_burst_reader
  import avm_burst_reader_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int COUNT_W     = 15,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  output logic [3:0]         avm_byteenable,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [31:0]        st_data,
  output logic               st_valid,
  input  logic               st_ready
`ifdef AVM_BURST_READER_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        bp_cycles
`endif
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic                 abort_q, abort_d;
  logic                 hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_empty, fifo_full;
  logic                        fifo_push, fifo_pop, fifo_flush;
  logic                        credit_ok, read_req, accept;

  avm_burst_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (avm_readdata),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .rdata   (st_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Outstanding reads are counted against FIFO space so every return has a slot.
  // hold_q keeps a stalled request asserted after abort until it is accepted.
  always_comb begin
    credit_ok  = (remaining_q != '0)
              && (32'(pending_q) < 32'(MAX_PENDING))
              && ((32'(fifo_count) + 32'(pending_q)) < 32'(FIFO_DEPTH));
    read_req   = (state_q == ISSUE) && (hold_q || (credit_ok && !abort_q));
    accept     = read_req && !avm_waitrequest;
    fifo_flush = abort_q;
    fifo_push  = avm_readdatavalid && !abort_q;
    fifo_pop   = !fifo_empty && st_ready;
    pending_d  = pending_q + PEND_W'(accept) - PEND_W'(avm_readdatavalid);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    abort_d     = abort_q;
    aborted_d   = aborted_q;
    hold_d      = read_req && avm_waitrequest;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          addr_d      = base_addr & ~ADDR_W'(3);
          remaining_d = word_count;
          aborted_d   = 1'b0;
          state_d     = (word_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) abort_d = 1'b1;
        if (accept) begin
          addr_d      = addr_q + ADDR_W'(WORD_BYTES);
          remaining_d = remaining_q - COUNT_W'(1);
        end
        if ((remaining_d == '0) || (abort_q && !read_req)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) abort_d = 1'b1;
        // Under abort the FIFO is being flushed, so only returns matter.
        if ((pending_q == '0) && (fifo_empty || abort_q)) begin
          state_d   = DONE;
          aborted_d = abort_q;
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= '0;
      abort_q     <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      abort_q     <= abort_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_push && fifo_full && !fifo_pop));

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_req;
  assign avm_byteenable = BE_ALL;
  assign st_valid       = !fifo_empty;

`ifdef AVM_BURST_READER_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bp_q, bp_d;

  always_comb begin
    stall_d = stall_q;
    bp_d    = bp_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
      bp_d    = '0;
    end else begin
      if (read_req && avm_waitrequest && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (st_valid && !st_ready && (bp_q != '1))          bp_d    = bp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      stall_q <= stall_d;
      bp_q    <= bp_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bp_cycles    = bp_q;
`endif

endmodule

// File: tb/tb_avm_burst_reader.sv
module tb_avm_burst_reader;

  localparam int ADDR_W      = 16;
  localparam int COUNT_W     = 15;
  localparam int FIFO_DEPTH  = 8;
  localparam int MAX_PENDING = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  base_addr = '0;
  logic [COUNT_W-1:0] word_count = '0;
  logic               abort = 1'b0;
  logic               busy, done, aborted;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_read;
  logic [3:0]         avm_byteenable;
  logic               avm_waitrequest = 1'b0;
  logic [31:0]        avm_readdata = '0;
  logic               avm_readdatavalid = 1'b0;
  logic [31:0]        st_data;
  logic               st_valid;
  logic               st_ready = 1'b0;
`ifdef AVM_BURST_READER_STATS_EN
  logic [31:0]        stall_cycles, bp_cycles;
`endif

  always #5 clk = ~clk;

  avm_burst_reader #(
    .ADDR_W      (ADDR_W),
    .COUNT_W     (COUNT_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
`ifdef AVM_BURST_READER_STATS_EN
    ,
    .stall_cycles      (stall_cycles),
    .bp_cycles         (bp_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference memory and transfer model
  logic [31:0] mem [16384];
  typedef struct { int due; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] exp_q[$];

  logic [15:0] xbase;
  int xcount;
  int cyc = 0;
  int acc_cnt, ret_cnt, pop_cnt, last_due;
  int start_cyc, done_cyc, done_cnt = 0;
  int first_pop, last_pop;
  int acc_limit, stall_m, bp_m;
  bit in_xfer = 0, in_abort = 0, rd_seen;
  bit prev_stall = 0, prev_bp = 0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;

  // Knobs set by the main sequence
  int wait_pct = 0, ready_pct = 100, lat_min = 1, lat_max = 1;
  int abort_after = 0, stall_idx = -1, stall_len = 0, stall_left = 0;
  int ready_block = 0, ready_block_end = 0;
  bit idle_abort = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] b, input int k);
    logic [13:0] idx;
    idx = 14'(int'(b >> 2) + k);
    return mem[idx];
  endfunction

  // Slave, stream sink and checker: drive at negedge, sample 1ns later,
  // account the events that the following posedge will commit.
  initial begin : slave_mon
    ret_t r;
    bit   accept, pop;
    int   lat;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rq.delete();
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        abort             = 1'b0;
        in_xfer = 0; in_abort = 0; prev_stall = 0; prev_bp = 0;
        acc_cnt = 0; ret_cnt = 0; pop_cnt = 0; last_due = 0;
        continue;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = r.data;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom();
      end
      abort = in_xfer ? (abort_after > 0 && acc_cnt >= abort_after) : idle_abort;
      if (cyc < ready_block_end) st_ready = 1'b0;
      else st_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (avm_read) begin
        if (acc_cnt == stall_idx && stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      #1;
      accept = avm_read && !avm_waitrequest;
      pop    = st_valid && st_ready;

      if (start && !busy && !in_xfer) begin
        in_xfer = 1; in_abort = 0; start_cyc = cyc;
        acc_cnt = 0; ret_cnt = 0; pop_cnt = 0; last_due = 0;
        stall_m = 0; bp_m = 0; rd_seen = 0; first_pop = -1; last_pop = -1;
        stall_left = stall_len;
        ready_block_end = (ready_block > 0) ? cyc + 1 + ready_block : 0;
      end
      if (in_xfer && cyc == start_cyc + 1) begin
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("aborted_cleared", aborted, 1'b0);
      end
      if (avm_read && in_xfer) rd_seen = 1;
      if (abort && in_xfer && !in_abort) begin
        in_abort  = 1;
        acc_limit = acc_cnt + int'(accept) + int'(avm_read && avm_waitrequest);
      end

      if (prev_stall) begin
        check_eq("hold_read", avm_read, 1'b1);
        check_eq("hold_addr", avm_address, prev_addr);
      end
      if (prev_bp && !in_abort) begin
        check_eq("st_hold_valid", st_valid, 1'b1);
        check_eq("st_hold_data", st_data, prev_data);
      end

      if (accept) begin
        check_eq("read_in_xfer", in_xfer, 1'b1);
        check_eq("rd_addr", avm_address, 16'(xbase + 16'(4 * acc_cnt)));
        check_eq("rd_within_count", acc_cnt < xcount, 1'b1);
        if (!in_abort) begin
          check_eq("credit_pending", (acc_cnt - ret_cnt) < MAX_PENDING, 1'b1);
          check_eq("credit_fifo", (acc_cnt - pop_cnt) < FIFO_DEPTH, 1'b1);
        end
        lat = $urandom_range(lat_min, lat_max);
        r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.data = mem_word(xbase, acc_cnt);
        last_due = r.due;
        rq.push_back(r);
      end

      if (pop) begin
        check_eq("st_word_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("st_data", st_data, exp_q.pop_front());
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end

      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_in_xfer", in_xfer, 1'b1);
        check_eq("done_busy_low", busy, 1'b0);
        check_eq("done_aborted", aborted, in_abort);
        check_eq("done_no_pending", acc_cnt - ret_cnt, 0);
        check_eq("done_st_valid", st_valid, 1'b0);
        check_eq("byteenable", avm_byteenable, 4'hF);
        if (!in_abort) begin
          check_eq("done_all_read", acc_cnt, xcount);
          check_eq("done_all_streamed", exp_q.size(), 0);
        end else begin
          check_eq("abort_no_new_reads", acc_cnt <= acc_limit, 1'b1);
        end
`ifdef AVM_BURST_READER_STATS_EN
        check_eq("stall_cycles", stall_cycles, stall_m);
        check_eq("bp_cycles", bp_cycles, bp_m);
`endif
        in_xfer = 0;
      end

      if (accept) acc_cnt++;
      if (avm_readdatavalid) ret_cnt++;
      if (pop) pop_cnt++;
      if (avm_read && avm_waitrequest) stall_m++;
      if (st_valid && !st_ready) bp_m++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      prev_bp    = st_valid && !st_ready;
      prev_data  = st_data;
    end
  end

  task automatic run_xfer(input logic [15:0] b, input int n);
    int d0;
    xbase  = b & 16'hFFFC;
    xcount = n;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(mem_word(xbase, k));
    base_addr  = b;
    word_count = COUNT_W'(n);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    check_eq("xfer_finished", done_cnt != d0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("done_once", done_cnt - d0, 1);
    check_eq("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_aborted"}, aborted, 1'b0);
    check_eq({tag, "_read"}, avm_read, 1'b0);
    check_eq({tag, "_addr"}, avm_address, 16'h0);
    check_eq({tag, "_st_valid"}, st_valid, 1'b0);
  endtask

  initial begin : main
    int n, b;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait, latency 1, always ready: one word per cycle after startup
    run_xfer(16'h0100, 5);
    check_eq("first_pop_latency", first_pop - start_cyc, 3);
    check_eq("pop_back_to_back", last_pop - first_pop, 4);

    // Three-cycle stall on the second read
    stall_idx = 1; stall_len = 3;
    run_xfer(16'h0100, 5);
    stall_idx = -1; stall_len = 0;

    // Long backpressure with more words than FIFO space
    ready_block = 20; lat_max = 2;
    run_xfer(16'h2000, 16);
    ready_block = 0;

    // Abort while idle has no effect; then an empty transfer
    idle_abort = 1;
    repeat (3) @(negedge clk);
    idle_abort = 0;
    run_xfer(16'h0040, 0);
    check_eq("zero_done_latency", done_cyc - start_cyc, 2);
    check_eq("zero_no_reads", rd_seen, 1'b0);

    // Abort after three accepted reads
    lat_min = 3; lat_max = 3; abort_after = 3;
    run_xfer(16'h0300, 10);
    abort_after = 0;
    check_eq("aborted_sticky", aborted, 1'b1);
    check_eq("abort_partial", acc_cnt < 10, 1'b1);

    // Address wrap at the top of the space
    lat_min = 1; lat_max = 2;
    run_xfer(16'hFFF8, 4);

    // Randomised transfers
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(0, 65535);
      n = $urandom_range(1, 40);
      wait_pct  = $urandom_range(0, 40);
      ready_pct = $urandom_range(30, 100);
      lat_max   = $urandom_range(1, 4);
      abort_after = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      run_xfer(16'(b), n);
      abort_after = 0;
    end

    // Reset pulsed in the middle of a transfer
    wait_pct = 0; ready_pct = 50; lat_max = 2;
    xbase = 16'h0500; xcount = 30;
    exp_q.delete();
    for (int k = 0; k < 30; k++) exp_q.push_back(mem_word(16'h0500, k));
    base_addr = 16'h0500; word_count = COUNT_W'(30);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("mid_busy", busy, 1'b1);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    ready_pct = 100;
    run_xfer(16'h0800, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/avm_burst_reader.md
Name: avm_burst_reader

Overview:
- Avalon-MM read master: the initiator side of the 32-bit word-addressed data memory slave.
- Fetches a programmed block of consecutive 32-bit words (e.g. RANSAC point coordinates) from memory.
- Streams the words out on an Avalon-ST source to the hardware RANSAC datapath, so the datapath reads point data without NIOS involvement.
- Sits between the system interconnect (master port) and the accelerator (stream port).

Parameters:
- ADDR_W, 16, byte-address width of the master port (16384 words x 4 bytes).
- COUNT_W, 15, width of the word-count register (max 16384 words).
- FIFO_DEPTH, 8, depth of the internal response FIFO in words; power of two, minimum 2.
- MAX_PENDING, 4, maximum reads accepted by the slave but not yet returned.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- base_addr  in  ADDR_W  byte start address, sampled on start; bits [1:0] ignored (forced 0)
- word_count  in  COUNT_W  number of words, sampled on start
- abort  in  1  level; stops the transfer early
- busy  out  1  high from the cycle after start until the done pulse
- done  out  1  one-cycle completion pulse
- aborted  out  1  sticky; set when the last transfer ended by abort; cleared on start
- avm_address  out  ADDR_W  master byte address
- avm_read  out  1  read request
- avm_byteenable  out  4  constant 4'b1111
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  returned data
- avm_readdatavalid  in  1  returned data valid
- st_data  out  32  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready

Behaviour:
- Reset values (all asynchronous on reset_n low):
  - busy=0, done=0, aborted=0, avm_read=0, avm_address=0, st_valid=0.
  - FIFO empty; pending and issue counters 0; state IDLE.
- State IDLE:
  - On start, latch addr=base_addr&~3 and remaining=word_count; clear aborted.
  - word_count=0: go to DONE.
  - Otherwise go to ISSUE.
  - start in any state other than IDLE is ignored.
- State ISSUE:
  - avm_read is asserted when remaining>0 and pending<MAX_PENDING and (fifo_count+pending)<FIFO_DEPTH.
  - avm_address and avm_read hold stable while avm_waitrequest=1.
  - A read is accepted on a cycle with avm_read=1 and avm_waitrequest=0. On acceptance: addr+=4 (wraps modulo 2^ADDR_W), remaining-=1, pending+=1.
  - When remaining reaches 0, go to DRAIN.
- State DRAIN:
  - Waits for pending=0 and FIFO empty; then go to DONE.
- State DONE:
  - done=1 for exactly one cycle; busy falls in the same cycle; then IDLE.
- Response path:
  - Each avm_readdatavalid decrements pending and pushes avm_readdata into the FIFO.
  - Acceptance and return in the same cycle leave pending unchanged.
  - The credit rule guarantees the FIFO never overflows; an overflow push is a design error and an assertion target.
- Stream:
  - st_valid = FIFO not empty; st_data = FIFO head (show-ahead).
  - Pop on st_valid & st_ready.
  - st_data is stable while st_valid=1 and st_ready=0.
- Ordering: words are emitted strictly in address order, each exactly once.
- Abort (level, sampled each cycle in ISSUE or DRAIN):
  - No new read is asserted from the next cycle on.
  - A read already asserted and stalled by waitrequest stays asserted until accepted (Avalon rule).
  - Then the FIFO is flushed, returns for outstanding reads are discarded, and the state waits for pending=0.
  - Then DONE with aborted=1.
  - Abort in IDLE has no effect.
- Simultaneous events:
  - FIFO push and pop in one cycle leave fifo_count unchanged.
  - A new start may arrive in the cycle after done.
- Throughput: with waitrequest=0, read latency 1 and st_ready=1, one word per cycle after a 2-cycle startup.

Optional Feature:
- Macro: AVM_BURST_READER_STATS_EN.
- Defined:
  - Adds output stall_cycles [31:0]: counts cycles with avm_read=1 and avm_waitrequest=1 during the transfer, saturating at 2^32-1.
  - Adds output bp_cycles [31:0]: counts cycles with st_valid=1 and st_ready=0, saturating at 2^32-1.
  - Both are cleared on start and on reset, and hold their value after done.
- Undefined: these ports and the counters are absent; behaviour is otherwise identical.

Decomposition:
- Package avm_burst_reader_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the word-size constant WORD_BYTES=4;
  - the byteenable constant BE_ALL=4'b1111.
- One sub-module, avm_burst_reader_fifo: synchronous show-ahead FIFO with push, pop, flush, count, empty and full, using the same clk/reset_n.

Test Plan:
- Zero-wait slave, latency 1, base_addr=0x0100, word_count=5, st_ready=1 -> reads to 0x0100..0x0110, st_data=mem[64..68] in order, done once, busy low after.
- Slave inserts waitrequest=1 for 3 cycles on the 2nd read -> avm_address holds 0x0104 across the stall; stream data unchanged; stats build reports stall_cycles=3.
- st_ready=0 for 20 cycles, FIFO_DEPTH=8, word_count=16 -> at most 8 reads outstanding+buffered, no overflow; all 16 words delivered after ready returns.
- word_count=0 -> no avm_read; done pulses 2 cycles after start; aborted=0.
- abort asserted after 3 accepted reads with 2 pending, word_count=10 -> no further reads; late returns discarded; st_valid=0 after flush; done with aborted=1.
- base_addr=0xFFF8, word_count=4 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004; reset_n pulsed low mid-transfer -> all outputs return to reset values immediately.
